// File: rtl/axi_read_arbiter.sv
// axi_read_arbiter: shares one AXI read channel (AR/R) between the instruction-fetch
// and data-load requesters. Only one burst is outstanding at a time. When both sides
// request together, the grant alternates round-robin. An instruction flush drains the
// in-flight instruction burst without forwarding its beats.
module axi_read_arbiter #(
  parameter logic [3:0]  INST_ID = 4'd0,
  parameter logic [3:0]  DATA_ID = 4'd1,
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] inst_araddr,
  input  logic [3:0]        inst_arlen,
  input  logic [2:0]        inst_arsize,
  input  logic              inst_arvalid,
  output logic              inst_arready,
  input  logic              inst_flush,
  output logic [DATA_W-1:0] inst_rdata,
  output logic              inst_rvalid,
  output logic              inst_rlast,
  input  logic [ADDR_W-1:0] data_araddr,
  input  logic [3:0]        data_arlen,
  input  logic [2:0]        data_arsize,
  input  logic              data_arvalid,
  output logic              data_arready,
  output logic [DATA_W-1:0] data_rdata,
  output logic              data_rvalid,
  output logic              data_rlast,
  output logic [3:0]        m_arid,
  output logic [ADDR_W-1:0] m_araddr,
  output logic [3:0]        m_arlen,
  output logic [2:0]        m_arsize,
  output logic [1:0]        m_arburst,
  output logic [1:0]        m_arlock,
  output logic [3:0]        m_arcache,
  output logic [2:0]        m_arprot,
  output logic              m_arvalid,
  input  logic              m_arready,
  input  logic [3:0]        m_rid,
  input  logic [DATA_W-1:0] m_rdata,
  input  logic [1:0]        m_rresp,
  input  logic              m_rlast,
  input  logic              m_rvalid,
  output logic              m_rready
);

  typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;

  state_t state;
  logic   owner;       // 0 = instruction side, 1 = data side
  logic   last_grant;  // side granted most recently (same encoding as owner)
  logic   discard;     // drop the remaining beats of the current instruction burst

  logic inst_req;
  logic grant_inst;
  logic grant_data;
  logic beat_ok;

  // The response is never inspected. It is kept only so the port has a load.
  logic unused_rresp;
  assign unused_rresp = ^m_rresp;

  assign m_arburst = 2'b01;
  assign m_arlock  = 2'b00;
  assign m_arcache = 4'b0000;
  assign m_arprot  = 3'b000;

  // Arbitration in IDLE: a single requester wins, and contention goes to the side not granted last
  always_comb begin
    inst_req   = inst_arvalid & ~inst_flush;
    grant_inst = 1'b0;
    grant_data = 1'b0;
    if (state == IDLE) begin
      if (inst_req && data_arvalid) begin
        grant_data = ~last_grant;
        grant_inst = last_grant;
      end else begin
        grant_inst = inst_req;
        grant_data = data_arvalid;
      end
    end
  end

  assign inst_arready = grant_inst;
  assign data_arready = grant_data;

  // Beats that carry a foreign ID are still consumed (rready stays high) but go nowhere
  assign beat_ok     = (state == DATA) & m_rvalid & (m_rid == (owner ? DATA_ID : INST_ID));
  assign inst_rvalid = beat_ok & ~owner & ~discard & ~inst_flush;
  assign data_rvalid = beat_ok & owner & ~discard;
  assign inst_rlast  = inst_rvalid & m_rlast;
  assign data_rlast  = data_rvalid & m_rlast;
  assign inst_rdata  = m_rdata;
  assign data_rdata  = m_rdata;

  // Burst sequencing: grant and latch in IDLE, hold AR in ADDR, drain R until RLAST in DATA
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      owner      <= 1'b0;
      last_grant <= 1'b0;
      discard    <= 1'b0;
      m_arid     <= '0;
      m_araddr   <= '0;
      m_arlen    <= '0;
      m_arsize   <= '0;
      m_arvalid  <= 1'b0;
      m_rready   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_inst || grant_data) begin
            owner      <= grant_data;
            last_grant <= grant_data;
            discard    <= 1'b0;
            m_arid     <= grant_data ? DATA_ID : INST_ID;
            m_araddr   <= grant_data ? data_araddr : inst_araddr;
            m_arlen    <= grant_data ? data_arlen : inst_arlen;
            m_arsize   <= grant_data ? data_arsize : inst_arsize;
            m_arvalid  <= 1'b1;
            state      <= ADDR;
          end
        end
        ADDR: begin
          if (inst_flush && !owner) discard <= 1'b1;
          if (m_arready) begin
            m_arvalid <= 1'b0;
            m_rready  <= 1'b1;
            state     <= DATA;
          end
        end
        DATA: begin
          if (inst_flush && !owner) discard <= 1'b1;
          if (beat_ok && m_rlast) begin
            m_rready <= 1'b0;
            discard  <= 1'b0;
            state    <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_read_arbiter.sv
// Directed bench for axi_read_arbiter. The bench plays the role of both requesters and
// of the AXI slave. Inputs change 1 ns after the rising edge, and outputs are checked 1 ns later.
module tb_axi_read_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] inst_araddr, data_araddr, m_araddr, m_rdata, inst_rdata, data_rdata;
  logic [3:0]  inst_arlen, data_arlen, m_arid, m_arlen, m_arcache, m_rid;
  logic [2:0]  inst_arsize, data_arsize, m_arsize, m_arprot;
  logic [1:0]  m_arburst, m_arlock, m_rresp;
  logic        inst_arvalid, inst_arready, inst_flush, inst_rvalid, inst_rlast;
  logic        data_arvalid, data_arready, data_rvalid, data_rlast;
  logic        m_arvalid, m_arready, m_rlast, m_rvalid, m_rready;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  axi_read_arbiter #(.INST_ID(4'd0), .DATA_ID(4'd1), .ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .reset(reset),
    .inst_araddr(inst_araddr), .inst_arlen(inst_arlen), .inst_arsize(inst_arsize),
    .inst_arvalid(inst_arvalid), .inst_arready(inst_arready), .inst_flush(inst_flush),
    .inst_rdata(inst_rdata), .inst_rvalid(inst_rvalid), .inst_rlast(inst_rlast),
    .data_araddr(data_araddr), .data_arlen(data_arlen), .data_arsize(data_arsize),
    .data_arvalid(data_arvalid), .data_arready(data_arready),
    .data_rdata(data_rdata), .data_rvalid(data_rvalid), .data_rlast(data_rlast),
    .m_arid(m_arid), .m_araddr(m_araddr), .m_arlen(m_arlen), .m_arsize(m_arsize),
    .m_arburst(m_arburst), .m_arlock(m_arlock), .m_arcache(m_arcache), .m_arprot(m_arprot),
    .m_arvalid(m_arvalid), .m_arready(m_arready), .m_rid(m_rid), .m_rdata(m_rdata),
    .m_rresp(m_rresp), .m_rlast(m_rlast), .m_rvalid(m_rvalid), .m_rready(m_rready)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  // The slave holds ARREADY low for 'waits' cycles, then completes the AR handshake.
  task automatic ar_accept(input int unsigned waits);
    for (int i = 0; i < int'(waits); i++) begin
      nxt();
      check("ar_hold", 32'(m_arvalid), 1);
    end
    m_arready = 1'b1;
    nxt();
    m_arready = 1'b0;
    #1;
    check("ar_drop", 32'(m_arvalid), 0);
    check("rready_on", 32'(m_rready), 1);
  endtask

  // Present one R beat for one cycle and check where it is routed.
  task automatic beat(input logic [3:0] id, input logic [31:0] d, input logic last,
                      input logic exp_i, input logic exp_d);
    m_rvalid = 1'b1;
    m_rid    = id;
    m_rdata  = d;
    m_rlast  = last;
    #1;
    check("rready_beat", 32'(m_rready), 1);
    check("inst_rvalid", 32'(inst_rvalid), 32'(exp_i));
    check("data_rvalid", 32'(data_rvalid), 32'(exp_d));
    if (exp_i) begin
      check("inst_rdata", inst_rdata, d);
      check("inst_rlast", 32'(inst_rlast), 32'(last));
    end
    if (exp_d) begin
      check("data_rdata", data_rdata, d);
      check("data_rlast", 32'(data_rlast), 32'(last));
    end
    nxt();
    m_rvalid = 1'b0;
    m_rlast  = 1'b0;
  endtask

  initial begin
    logic exp_d;
    inst_araddr = '0; inst_arlen = '0; inst_arsize = '0; inst_arvalid = 1'b0; inst_flush = 1'b0;
    data_araddr = '0; data_arlen = '0; data_arsize = '0; data_arvalid = 1'b0;
    m_arready = 1'b0; m_rid = '0; m_rdata = '0; m_rresp = '0; m_rlast = 1'b0; m_rvalid = 1'b0;

    // Reset values
    repeat (2) @(posedge clk);
    #1;
    check("rst_arvalid", 32'(m_arvalid), 0);
    check("rst_rready", 32'(m_rready), 0);
    check("rst_iarready", 32'(inst_arready), 0);
    check("rst_darready", 32'(data_arready), 0);
    check("rst_irvalid", 32'(inst_rvalid), 0);
    check("rst_drvalid", 32'(data_rvalid), 0);
    check("rst_arid", 32'(m_arid), 0);
    check("rst_araddr", m_araddr, 0);
    check("rst_arburst", 32'(m_arburst), 1);
    check("rst_arlock", 32'(m_arlock), 0);
    check("rst_arcache", 32'(m_arcache), 0);
    check("rst_arprot", 32'(m_arprot), 0);
    reset = 1'b0;
    nxt();

    // Contention right after reset: data wins first, inst follows after one idle cycle
    inst_araddr = 32'h1000_0000; inst_arlen = 4'd0; inst_arsize = 3'd2; inst_arvalid = 1'b1;
    data_araddr = 32'h2000_0040; data_arlen = 4'd0; data_arsize = 3'd2; data_arvalid = 1'b1;
    #1;
    check("A_data_gnt", 32'(data_arready), 1);
    check("A_inst_wait", 32'(inst_arready), 0);
    nxt();
    data_arvalid = 1'b0;
    #1;
    check("A_arid", 32'(m_arid), 1);
    check("A_araddr", m_araddr, 32'h2000_0040);
    check("A_inst_hold", 32'(inst_arready), 0);
    ar_accept(0);
    beat(4'd0, 32'h0000_0BAD, 1'b1, 1'b0, 1'b0);  // foreign ID: consumed, ignored, no end
    beat(4'd1, 32'h0000_00D0, 1'b1, 1'b0, 1'b1);
    #1;
    check("A_inst_gnt", 32'(inst_arready), 1);
    nxt();
    inst_arvalid = 1'b0;
    #1;
    check("A_arid2", 32'(m_arid), 0);
    ar_accept(0);
    beat(4'd0, 32'h0000_0011, 1'b1, 1'b1, 1'b0);

    // Inst only, 8-beat burst, ARREADY delayed
    inst_araddr = 32'h1FC0_0020; inst_arlen = 4'd7; inst_arsize = 3'd2; inst_arvalid = 1'b1;
    #1;
    check("B_inst_gnt", 32'(inst_arready), 1);
    check("B_data_gnt", 32'(data_arready), 0);
    nxt();
    inst_arvalid = 1'b0;
    #1;
    check("B_arvalid", 32'(m_arvalid), 1);
    check("B_arid", 32'(m_arid), 0);
    check("B_araddr", m_araddr, 32'h1FC0_0020);
    check("B_arlen", 32'(m_arlen), 7);
    check("B_arsize", 32'(m_arsize), 2);
    check("B_arburst", 32'(m_arburst), 1);
    ar_accept(2);
    for (int i = 0; i < 8; i++) beat(4'd0, 32'(i), (i == 7), 1'b1, 1'b0);
    #1;
    check("B_idle_rready", 32'(m_rready), 0);
    check("B_idle_arvalid", 32'(m_arvalid), 0);

    // Four back-to-back contended bursts: data, inst, data, inst
    inst_arlen = 4'd0; data_arlen = 4'd0;
    for (int k = 0; k < 4; k++) begin
      exp_d = (k % 2 == 0);
      inst_arvalid = 1'b1;
      data_arvalid = 1'b1;
      #1;
      check("C_data_gnt", 32'(data_arready), 32'(exp_d));
      check("C_inst_gnt", 32'(inst_arready), 32'(!exp_d));
      nxt();
      if (exp_d) data_arvalid = 1'b0;
      else inst_arvalid = 1'b0;
      #1;
      check("C_arid", 32'(m_arid), exp_d ? 32'd1 : 32'd0);
      ar_accept(0);
      beat(exp_d ? 4'd1 : 4'd0, 32'hC0 + 32'(k), 1'b1, !exp_d, exp_d);
    end
    data_arvalid = 1'b0;
    inst_arvalid = 1'b0;

    // Flush while the inst burst is in ADDR: AR is held, and all beats are drained silently
    inst_araddr = 32'h1FC0_0100; inst_arlen = 4'd7; inst_arvalid = 1'b1;
    #1;
    check("D_gnt", 32'(inst_arready), 1);
    nxt();
    inst_arvalid = 1'b0;
    inst_flush = 1'b1;
    #1;
    check("D_arvalid", 32'(m_arvalid), 1);
    nxt();
    inst_flush = 1'b0;
    #1;
    check("D_arvalid_kept", 32'(m_arvalid), 1);
    ar_accept(0);
    for (int i = 0; i < 8; i++) beat(4'd0, 32'h100 + 32'(i), (i == 7), 1'b0, 1'b0);
    #1;
    check("D_idle", 32'(m_rready), 0);
    inst_arlen = 4'd0; inst_arvalid = 1'b1;
    #1;
    check("D2_gnt", 32'(inst_arready), 1);
    nxt();
    inst_arvalid = 1'b0;
    #1;
    ar_accept(0);
    beat(4'd0, 32'h0000_0055, 1'b1, 1'b1, 1'b0);

    // Flush on beat 3 of 8: beats 1-2 are forwarded, and the rest are suppressed
    inst_arlen = 4'd7; inst_arvalid = 1'b1;
    #1;
    check("E_gnt", 32'(inst_arready), 1);
    nxt();
    inst_arvalid = 1'b0;
    #1;
    ar_accept(0);
    for (int i = 0; i < 8; i++) begin
      if (i == 2) inst_flush = 1'b1;
      beat(4'd0, 32'h200 + 32'(i), (i == 7), (i < 2), 1'b0);
      inst_flush = 1'b0;
    end
    #1;
    check("E_idle", 32'(m_rready), 0);

    // Asynchronous reset on data beat 4, then a single-beat data burst
    data_araddr = 32'h3000_0000; data_arlen = 4'd7; data_arvalid = 1'b1;
    #1;
    check("F_gnt", 32'(data_arready), 1);
    nxt();
    data_arvalid = 1'b0;
    #1;
    ar_accept(0);
    for (int i = 0; i < 3; i++) beat(4'd1, 32'h300 + 32'(i), 1'b0, 1'b0, 1'b1);
    m_rvalid = 1'b1; m_rid = 4'd1; m_rdata = 32'h303;
    #1;
    check("F_beat4", 32'(data_rvalid), 1);
    reset = 1'b1;
    #1;
    check("F_rst_rvalid", 32'(data_rvalid), 0);
    check("F_rst_rlast", 32'(data_rlast), 0);
    check("F_rst_rready", 32'(m_rready), 0);
    check("F_rst_arvalid", 32'(m_arvalid), 0);
    check("F_rst_arid", 32'(m_arid), 0);
    check("F_rst_araddr", m_araddr, 0);
    m_rvalid = 1'b0;
    nxt();
    reset = 1'b0;
    #1;
    data_arlen = 4'd0; data_arvalid = 1'b1;
    #1;
    check("F2_gnt", 32'(data_arready), 1);
    nxt();
    data_arvalid = 1'b0;
    #1;
    check("F2_arid", 32'(m_arid), 1);
    check("F2_arlen", 32'(m_arlen), 0);
    ar_accept(0);
    beat(4'd1, 32'h0000_0077, 1'b1, 1'b0, 1'b1);
    #1;
    check("F2_idle", 32'(m_rready), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
